my_div_unsigned: RTL and testbench
==================================

MY_DIV_UNSIGNED -- requirements
Module: my_div_unsigned

Interface
REQ-001 a_bits, 1, dividend width in bits.
REQ-002 a_point, 1, dividend fractional bits.
REQ-003 b_bits, 1, divisor width in bits.
REQ-004 b_point, 1, divisor fractional bits.
REQ-005 c_bits, 1, quotient width in bits.
REQ-006 c_point, 1, quotient fractional bits.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 in_valid  input  1  operands a, b present.
REQ-010 in_ready  output  1  block can accept operands.
REQ-011 a  input  a_bits  unsigned fixed-point dividend.
REQ-012 b  input  b_bits  unsigned fixed-point divisor.
REQ-013 out_valid  output  1  result c and flags valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 c  output  c_bits  unsigned fixed-point quotient.
REQ-016 div_by_zero  output  1  result came from b == 0.
REQ-017 overflow  output  1  quotient saturated.

Function
REQ-018 Shift constant lshift = c_point - a_point + b_point; numerator n = a << lshift when lshift >= 0, else a >> -lshift (discarded bits truncated); n_bits = a_bits + max(lshift, 0).
REQ-019 Quotient q = floor(n / b), computed by restoring division, one quotient bit per cycle, MSB first; remainder width b_bits+1.
REQ-020 States: IDLE, CALC, DONE; IDLE -> CALC on in_valid && in_ready; CALC -> DONE after exactly n_bits CALC cycles; DONE -> IDLE on out_ready.
REQ-021 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; no new operands accepted in DONE, even when out_ready = 1.
REQ-022 a and b are registered on the accepting edge; later input changes have no effect on the operation in flight.
REQ-023 Latency: out_valid rises on the n_bits-th rising edge after the accepting edge.
REQ-024 b == 0: same latency; c = all ones, div_by_zero = 1, overflow = 0.
REQ-025 b != 0 and q >= 2^c_bits: c = all ones, overflow = 1, div_by_zero = 0.
REQ-026 Otherwise c = q[c_bits-1:0], both flags 0.
REQ-027 c, div_by_zero and overflow are registered and held stable throughout DONE while out_ready = 0.

Reset
REQ-028 rst_n low: immediately state = IDLE, in_ready = 1 once rst_n is released, out_valid = 0, c = 0, div_by_zero = 0, overflow = 0, internal registers cleared.
REQ-029 Reset asserted during CALC or DONE discards the operation; no result is emitted afterwards.

Structure
REQ-030 State enum (IDLE/CALC/DONE) lives in the shared fixed-point package alongside a helper function computing lshift and n_bits from the six parameters.
REQ-031 One combinational sub-module my_div_step (partial remainder, divisor, next numerator bit -> new remainder, quotient bit) is instantiated once and reused every CALC cycle.

Verification
Parameters for all scenarios: a_bits = b_bits = c_bits = 8; a_point = b_point = c_point = 4; lshift = 4; n_bits = 12.
REQ-032 a = 0x30 (3.0), b = 0x20 (2.0) -> c = 0x18 (1.5), flags 0, out_valid 12 edges after accept.
REQ-033 a = 0x10 (1.0), b = 0x30 (3.0) -> c = 0x05 (truncated 0.3125), flags 0.
REQ-034 a = 0xFF, b = 0x01 -> c = 0xFF, overflow = 1, div_by_zero = 0.
REQ-035 a = 0x40, b = 0x00 -> c = 0xFF, div_by_zero = 1, overflow = 0, 12-cycle latency.
REQ-036 out_ready held 0 for 5 cycles in DONE -> c/flags stable, in_ready = 0; back-to-back in_valid accepted only on the edge after the out_ready handshake.
REQ-037 rst_n pulsed low at CALC cycle 6 -> outputs zero immediately, out_valid never asserts for that operation, next operation correct.

Source files
------------

// File: rtl/my_div_unsigned_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_div_unsigned_pkg
// Purpose  : Shared fixed-point definitions for the unsigned divider. It holds
//            the FSM state type and the numerator alignment helpers.
// Revision : 1.0 - initial release
// ============================================================================
package my_div_unsigned_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Left shift that aligns the dividend so that the integer quotient lands
   // on the quotient's fixed-point grid.
   function automatic int calc_lshift(input int a_point, input int b_point,
                                      input int c_point);
      return c_point - a_point + b_point;
   endfunction

   // Numerator width. A right shift drops bits, so it never widens.
   function automatic int calc_nbits(input int a_bits, input int a_point,
                                     input int b_point, input int c_point);
      int s;
      s = calc_lshift(a_point, b_point, c_point);
      return a_bits + ((s > 0) ? s : 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/my_div_step.sv
`default_nettype none
// ============================================================================
// Module   : my_div_step
// Purpose  : One restoring-division step. It shifts the next numerator bit
//            into the partial remainder and subtracts the divisor when that
//            subtraction does not go negative.
// Revision : 1.0 - initial release
// ============================================================================
module my_div_step
   import my_div_unsigned_pkg::*;
#(
   parameter int b_bits = 8
) (
   input  logic [b_bits:0]   i_rem,
   input  logic [b_bits-1:0] i_div,
   input  logic              i_bit,
   output logic [b_bits:0]   o_rem,
   output logic              o_q
);

   logic [b_bits+1:0] w_shift;
   logic [b_bits:0]   w_diff;
   logic              w_ge;

   // Compare at full width so no remainder bit is lost. The difference fits in
   // b_bits+1 bits whenever the subtraction is taken.
   assign w_shift = {i_rem, i_bit};
   assign w_ge    = (w_shift >= {2'b00, i_div});
   assign w_diff  = w_shift[b_bits:0] - {1'b0, i_div};
   assign o_rem   = w_ge ? w_diff : w_shift[b_bits:0];
   assign o_q     = w_ge;

endmodule
`default_nettype wire

// File: rtl/my_div_unsigned.sv
`default_nettype none
// ============================================================================
// Module   : my_div_unsigned
// Purpose  : Unsigned fixed-point sequential divider. It produces one quotient
//            bit per cycle with restoring division, saturates the result, and
//            flags divide-by-zero and overflow. A valid/ready handshake is used
//            on both the input and the output.
// Revision : 1.0 - initial release
// ============================================================================
module my_div_unsigned
   import my_div_unsigned_pkg::*;
#(
   parameter int a_bits  = 8,
   parameter int a_point = 4,
   parameter int b_bits  = 8,
   parameter int b_point = 4,
   parameter int c_bits  = 8,
   parameter int c_point = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [a_bits-1:0] a,
   input  logic [b_bits-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [c_bits-1:0] c,
   output logic              div_by_zero,
   output logic              overflow
);

   localparam int LSHIFT = calc_lshift(a_point, b_point, c_point);
   localparam int NBITS  = calc_nbits(a_bits, a_point, b_point, c_point);
   localparam int CNT_W  = $clog2(NBITS);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NBITS - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic                w_in_ready;
   logic                w_out_valid;

   logic [NBITS-1:0]    w_num_init;
   logic [NBITS-1:0]    r_num;
   logic [b_bits-1:0]   r_div;
   logic [b_bits:0]     r_rem;
   logic [c_bits-1:0]   r_quo;
   logic                r_sticky;
   logic [CNT_W-1:0]    r_cnt;
   logic [c_bits-1:0]   r_c;
   logic                r_dbz;
   logic                r_ovf;

   logic [b_bits:0]     w_rem_next;
   logic                w_qbit;
   logic [c_bits-1:0]   w_quo_next;
   logic                w_sticky_next;
   logic                w_dbz;
   logic                w_ovf;
   logic                w_last;

   // Align the dividend on the quotient grid. A right shift truncates.
   generate
      if (LSHIFT > 0) begin : g_shl
         assign w_num_init = {a, {LSHIFT{1'b0}}};
      end else if (LSHIFT == 0) begin : g_none
         assign w_num_init = a;
      end else begin : g_shr
         localparam int SHR = -LSHIFT;
         assign w_num_init = a >> SHR;
      end
   endgenerate

   my_div_step #(
      .b_bits (b_bits)
   ) u_step (
      .i_rem (r_rem),
      .i_div (r_div),
      .i_bit (r_num[NBITS-1]),
      .o_rem (w_rem_next),
      .o_q   (w_qbit)
   );

   // Only the low c_bits quotient bits are kept. Any bit shifted past them
   // sets a sticky flag that means the quotient is too large to represent.
   assign w_quo_next    = {r_quo[c_bits-2:0], w_qbit};
   assign w_sticky_next = r_sticky | r_quo[c_bits-1];
   assign w_dbz         = (r_div == '0);
   assign w_ovf         = !w_dbz && w_sticky_next;
   assign w_last        = (r_cnt == c_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_state_next = ST_CALC;
         end
         ST_CALC: begin
            if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Operand capture, iterative division and result registration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num    <= '0;
         r_div    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_sticky <= 1'b0;
         r_cnt    <= '0;
         r_c      <= '0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_num    <= w_num_init;
                  r_div    <= b;
                  r_rem    <= '0;
                  r_quo    <= '0;
                  r_sticky <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            ST_CALC: begin
               r_num    <= {r_num[NBITS-2:0], 1'b0};
               r_rem    <= w_rem_next;
               r_quo    <= w_quo_next;
               r_sticky <= w_sticky_next;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  r_dbz <= w_dbz;
                  r_ovf <= w_ovf;
                  r_c   <= (w_dbz || w_ovf) ? '1 : w_quo_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = w_out_valid;
   assign c           = r_c;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_my_div_unsigned.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_div_unsigned
// Purpose  : Self-checking bench for my_div_unsigned with 8-bit Q4.4 operands
//            and quotient. It runs directed and random operations against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_div_unsigned;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] c;
   logic       div_by_zero;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   my_div_unsigned #(
      .a_bits (8), .a_point (4),
      .b_bits (8), .b_point (4),
      .c_bits (8), .c_point (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .c           (c),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: q = floor((a * 2^4) / b), then saturate to 8 bits.
   task automatic ref_model(input logic [7:0] ea, input logic [7:0] eb,
                            output logic [7:0] ec, output logic edz, output logic eov);
      int q;
      edz = 1'b0;
      eov = 1'b0;
      if (eb == 8'h00) begin
         ec  = 8'hFF;
         edz = 1'b1;
      end else begin
         q = (int'(ea) * 16) / int'(eb);
         if (q > 255) begin
            ec  = 8'hFF;
            eov = 1'b1;
         end else begin
            ec = q[7:0];
         end
      end
   endtask

   // Present operands in IDLE and scramble the inputs right after the accepting edge.
   task automatic start_op(input logic [7:0] va, input logic [7:0] vb);
      for (int i = 0; i < 50 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      chk("in_ready_before_accept", in_ready, 1);
      a = va;
      b = vb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
   endtask

   task automatic check_result(input logic [7:0] va, input logic [7:0] vb, input int lat);
      logic [7:0] ec;
      logic edz, eov;
      ref_model(va, vb, ec, edz, eov);
      chk("latency", lat, 12);
      chk("c", c, ec);
      chk("div_by_zero", div_by_zero, edz);
      chk("overflow", overflow, eov);
   endtask

   // Hold the result for a number of cycles, then complete the output handshake.
   task automatic finish_op(input int hold);
      logic [7:0] c0;
      logic dz0, ov0;
      c0 = c; dz0 = div_by_zero; ov0 = overflow;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_c", c, c0);
         chk("hold_flags", {div_by_zero, overflow}, {dz0, ov0});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("after_handshake_out_valid", out_valid, 0);
      chk("after_handshake_in_ready", in_ready, 1);
   endtask

   task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input int hold);
      int lat;
      start_op(va, vb);
      wait_result(lat);
      check_result(va, vb, lat);
      finish_op(hold);
   endtask

   initial begin
      int lat;
      logic saw;
      logic [7:0] ra, rb;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_c", c, 0);
      chk("reset_flags", {div_by_zero, overflow}, 2'b00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_in_ready", in_ready, 1);

      // Directed cases.
      do_op(8'h30, 8'h20, 0);   // 3.0 / 2.0 = 1.5
      do_op(8'h10, 8'h30, 0);   // 1.0 / 3.0 -> 0x05
      do_op(8'hFF, 8'h01, 0);   // overflow
      do_op(8'h40, 8'h00, 0);   // divide by zero
      do_op(8'hFF, 8'h10, 0);   // largest non-saturating quotient, 0xFF
      do_op(8'h10, 8'h01, 0);   // quotient 256, smallest overflow
      do_op(8'h00, 8'h00, 0);   // 0/0 still flags divide by zero
      do_op(8'h30, 8'h20, 5);   // result held while out_ready is low

      // Back-to-back: in_valid held high through DONE is accepted only after the handshake.
      start_op(8'h10, 8'h30);
      wait_result(lat);
      check_result(8'h10, 8'h30, lat);
      a = 8'h30;
      b = 8'h20;
      in_valid = 1'b1;
      out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("b2b_done_in_ready", in_ready, 0);
         chk("b2b_done_c", c, 8'h05);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("b2b_handshake_in_ready", in_ready, 1);
      chk("b2b_handshake_out_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_accepted", in_ready, 0);
      wait_result(lat);
      check_result(8'h30, 8'h20, lat);
      finish_op(0);

      // Reset during CALC discards the operation.
      start_op(8'h30, 8'h20);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_c", c, 0);
      chk("midreset_flags", {div_by_zero, overflow}, 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk("midreset_no_result", saw, 0);
      do_op(8'h50, 8'h28, 1);   // 5.0 / 2.5 = 2.0

      // Random operations, some with a zero divisor.
      for (int i = 0; i < 25; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
         do_op(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
